// File: rtl/wb_copy_master.sv
// Wishbone B4 pipelined copy engine: one read then one write per word, one transaction in flight.
// Optional ack watchdog is enabled by defining WB_COPY_TIMEOUT_EN.
module wb_copy_master #(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_i,
    input  logic [31:0]          dst_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] count_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_stall_i,
    output logic [2:0]           dbg_state_o
);

    // Handshake: a request is accepted on a clock edge where stb=1 and stall=0;
    // the single outstanding transaction then ends on the first edge with ack or err.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t               state;
    logic [29:0]          src_q;
    logic [29:0]          dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] count_nxt;
    logic [29:0]          src_nxt;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_cnt;
`endif

    assign count_nxt   = count_o + LEN_WIDTH'(1);
    assign src_nxt     = src_q + 30'd1;
    assign wb_sel_o    = 4'hF;
    assign dbg_state_o = state;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            count_o  <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
`ifdef WB_COPY_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_q   <= src_i[31:2];
                        dst_q   <= dst_i[31:2];
                        len_q   <= len_i;
                        count_o <= '0;
                        err_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        if (len_i != '0) begin
                            state    <= RD_REQ;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= {src_i[31:2], 2'b00};
                        end else begin
                            state  <= FINISH;
                            done_o <= 1'b1;
                        end
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (abort_i) begin
                        state    <= FINISH;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        done_o   <= 1'b1;
                    end else if (!wb_stall_i) begin
                        state    <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
                        wb_stb_o <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (abort_i || wb_err_i) begin
                        // abort outranks err, so an aborted transfer never reports an error
                        err_o    <= !abort_i;
                        state    <= FINISH;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        done_o   <= 1'b1;
                    end else if (wb_ack_i) begin
                        if (state == RD_WAIT) begin
                            wb_dat_o <= wb_dat_i;
                            state    <= WR_REQ;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_adr_o <= {dst_q, 2'b00};
                        end else begin
                            count_o <= count_nxt;
                            src_q   <= src_nxt;
                            dst_q   <= dst_q + 30'd1;
                            wb_we_o <= 1'b0;
                            if (count_nxt == len_q) begin
                                state    <= FINISH;
                                wb_cyc_o <= 1'b0;
                                done_o   <= 1'b1;
                            end else begin
                                state    <= RD_REQ;
                                wb_stb_o <= 1'b1;
                                wb_adr_o <= {src_nxt, 2'b00};
                            end
                        end
                    end
`ifdef WB_COPY_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_o    <= 1'b1;
                        state    <= FINISH;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
